apu_frame_seq: RTL and testbench

Parametrised successor to the stub APU status block: implements the 2A03 frame sequencer (4-step/5-step), frame IRQ, per-channel length counters and the real $4015/$4017 register behaviour. Sits on the CPU register bus beside the channel generators. Its quarter/half-frame pulses clock the envelope, sweep and linear-counter logic in the channel blocks. Channel count and step periods are parameters so the same block serves reduced test builds and the full console.

---
 rtl/apu_pkg.sv | 35 +++
 rtl/apu_length_ctr.sv | 44 ++++
 rtl/apu_frame_seq.sv | 150 +++++++++++++++
 tb/tb_apu_frame_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apu_pkg : APU register map, length-counter lookup, sequencer mode   rev 1.0
// ---------------------------------------------------------------------------
package apu_pkg;

  localparam logic [15:0] ADDR_CH_BASE = 16'h4000;
  localparam logic [15:0] ADDR_STRIDE  = 16'h0004;
  localparam logic [15:0] REG_CTRL_OFS = 16'h0000;
  localparam logic [15:0] REG_LEN_OFS  = 16'h0003;
  localparam logic [15:0] ADDR_STATUS  = 16'h4015;
  localparam logic [15:0] ADDR_FRAME   = 16'h4017;

  typedef enum logic {
    SEQ_4STEP = 1'b0,
    SEQ_5STEP = 1'b1
  } seq_mode_t;

  function automatic logic [7:0] len_table(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apu_length_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apu_length_ctr : per-channel 8-bit length counter with halt flag    rev 1.0
// ---------------------------------------------------------------------------
module apu_length_ctr
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       ena,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_idx,
  input  logic       halt_we,
  input  logic       halt_in,
  input  logic       half_tick,
  output logic       active
);

  logic [7:0] count;
  logic       halt;

  // Priority: disable clear, then load, then half-frame decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
      halt  <= 1'b0;
    end else if (ce) begin
      if (halt_we)
        halt <= halt_in;
      if (clear)
        count <= 8'd0;
      else if (load && ena)
        count <= len_table(load_idx);
      else if (half_tick && (count != 8'd0) && !halt)
        count <= count - 8'd1;
    end
  end

  assign active = (count != 8'd0);

endmodule
`default_nettype wire

// File: rtl/apu_frame_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apu_frame_seq : 2A03 frame sequencer, frame IRQ, $4015/$4017, length ctrs rev 1.0
// ---------------------------------------------------------------------------
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281,
  parameter int CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cpu_ce,
  input  logic            i_reg_cs,
  input  logic            i_reg_wn,
  input  logic [15:0]     i_reg_addr,
  input  logic [7:0]      i_reg_wdata,
  output logic [7:0]      o_reg_rdata,
  input  logic            i_dmc_irq,
  output logic [N_CH-1:0] o_ch_ena,
  output logic [N_CH-1:0] o_len_active,
  output logic            o_qtr_frame,
  output logic            o_half_frame,
  output logic            o_irq_n
);

  localparam logic [CNT_W-1:0] S1_CNT = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2_CNT = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3_CNT = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4_CNT = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5_CNT = CNT_W'(STEP5);

  logic [CNT_W-1:0] seq_cnt;
  seq_mode_t        mode;
  logic             inhibit;
  logic             frame_irq;
  logic [N_CH-1:0]  ch_ena;
  logic             qtr_frame;
  logic             half_frame;
  logic [N_CH-1:0]  len_active;
  logic [3:0]       len4;

  logic wr, rd, wr_status, wr_frame, rd_status;
  logic step_qtr, step_half, step_irq, step_wrap;

  assign wr        = i_reg_cs & ~i_reg_wn & i_cpu_ce;
  assign rd        = i_reg_cs &  i_reg_wn & i_cpu_ce;
  assign wr_status = wr && (i_reg_addr == ADDR_STATUS);
  assign wr_frame  = wr && (i_reg_addr == ADDR_FRAME);
  assign rd_status = rd && (i_reg_addr == ADDR_STATUS);

  always_comb begin
    step_qtr  = 1'b0;
    step_half = 1'b0;
    step_irq  = 1'b0;
    step_wrap = 1'b0;
    if (seq_cnt == S1_CNT || seq_cnt == S3_CNT)
      step_qtr = 1'b1;
    if (seq_cnt == S2_CNT) begin
      step_qtr  = 1'b1;
      step_half = 1'b1;
    end
    if (mode == SEQ_4STEP && seq_cnt == S4_CNT) begin
      step_qtr  = 1'b1;
      step_half = 1'b1;
      step_irq  = 1'b1;
      step_wrap = 1'b1;
    end
    if (mode == SEQ_5STEP && seq_cnt == S5_CNT) begin
      step_qtr  = 1'b1;
      step_half = 1'b1;
      step_wrap = 1'b1;
    end
  end

  // A $4017 write overrides whatever step the sequencer would take this cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seq_cnt    <= '0;
      mode       <= SEQ_4STEP;
      inhibit    <= 1'b0;
      frame_irq  <= 1'b0;
      ch_ena     <= '0;
      qtr_frame  <= 1'b0;
      half_frame <= 1'b0;
    end else if (i_cpu_ce) begin
      if (wr_frame) begin
        seq_cnt    <= '0;
        mode       <= seq_mode_t'(i_reg_wdata[7]);
        inhibit    <= i_reg_wdata[6];
        qtr_frame  <= i_reg_wdata[7];
        half_frame <= i_reg_wdata[7];
      end else begin
        seq_cnt    <= step_wrap ? '0 : seq_cnt + CNT_W'(1);
        qtr_frame  <= step_qtr;
        half_frame <= step_half;
      end
      if (wr_frame && i_reg_wdata[6])
        frame_irq <= 1'b0;
      else if (!wr_frame && step_irq && !inhibit)
        frame_irq <= 1'b1;
      else if (rd_status)
        frame_irq <= 1'b0;
      if (wr_status)
        ch_ena <= i_reg_wdata[N_CH-1:0];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [15:0] CTRL_ADDR = ADDR_CH_BASE + 16'(k) * ADDR_STRIDE + REG_CTRL_OFS;
    localparam logic [15:0] LEN_ADDR  = ADDR_CH_BASE + 16'(k) * ADDR_STRIDE + REG_LEN_OFS;
    // The triangle keeps its halt flag in bit 7 (shared with the linear-counter control).
    localparam int HALT_BIT = (k == 2) ? 7 : 5;

    apu_length_ctr u_len (
      .clk       (i_clk),
      .rst       (i_rst),
      .ce        (i_cpu_ce),
      .ena       (ch_ena[k]),
      .clear     (wr_status & ~i_reg_wdata[k]),
      .load      (wr && (i_reg_addr == LEN_ADDR)),
      .load_idx  (i_reg_wdata[7:3]),
      .halt_we   (wr && (i_reg_addr == CTRL_ADDR)),
      .halt_in   (i_reg_wdata[HALT_BIT]),
      .half_tick (half_frame),
      .active    (len_active[k])
    );
  end

  assign len4 = 4'(len_active);

  always_comb begin
    o_reg_rdata = 8'h00;
    if (rd_status)
      o_reg_rdata = {i_dmc_irq, frame_irq, 2'b00, len4};
  end

  assign o_ch_ena      = ch_ena;
  assign o_len_active  = len_active;
  assign o_qtr_frame   = qtr_frame;
  assign o_half_frame  = half_frame;
  assign o_irq_n       = ~(frame_irq | i_dmc_irq);

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apu_frame_seq : directed bench for apu_frame_seq with shortened steps rev 1.0
// ---------------------------------------------------------------------------
module tb_apu_frame_seq;

  localparam int N_CH  = 4;
  localparam int S1    = 7;
  localparam int S2    = 14;
  localparam int S3    = 22;
  localparam int S4    = 29;
  localparam int S5    = 37;
  localparam int CNT_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce = 1'b0;
  logic        reg_cs = 1'b0;
  logic        reg_wn = 1'b0;
  logic [15:0] reg_addr = 16'h0000;
  logic [7:0]  reg_wdata = 8'h00;
  logic        dmc_irq = 1'b0;
  logic [7:0]  reg_rdata;
  logic [N_CH-1:0] ch_ena;
  logic [N_CH-1:0] len_active;
  logic        qtr_frame;
  logic        half_frame;
  logic        irq_n;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;   // sequencer value the next ce cycle will see
  int halfs    = 0;   // half-frame pulses observed since last cleared
  logic [7:0] rdv;

  apu_frame_seq #(
    .N_CH(N_CH), .STEP1(S1), .STEP2(S2), .STEP3(S3),
    .STEP4(S4), .STEP5(S5), .CNT_W(CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_ce     (cpu_ce),
    .i_reg_cs     (reg_cs),
    .i_reg_wn     (reg_wn),
    .i_reg_addr   (reg_addr),
    .i_reg_wdata  (reg_wdata),
    .o_reg_rdata  (reg_rdata),
    .i_dmc_irq    (dmc_irq),
    .o_ch_ena     (ch_ena),
    .o_len_active (len_active),
    .o_qtr_frame  (qtr_frame),
    .o_half_frame (half_frame),
    .o_irq_n      (irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ce-qualified cycle followed by one idle clock, so pulses are seen held.
  task automatic bus(input logic cs, input logic wn, input logic [15:0] a,
                     input logic [7:0] d, output logic [7:0] rdata);
    reg_cs = cs; reg_wn = wn; reg_addr = a; reg_wdata = d; cpu_ce = 1'b1;
    #1 rdata = reg_rdata;
    @(posedge clk); #1;
    if (half_frame) halfs++;
    pos++;
    if (cs && !wn && a == 16'h4017) pos = 0;
    cpu_ce = 1'b0; reg_cs = 1'b0; reg_wn = 1'b0; reg_addr = 16'h0; reg_wdata = 8'h0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    logic [7:0] unused_rd;
    bus(1'b0, 1'b0, 16'h0000, 8'h00, unused_rd);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    bus(1'b1, 1'b0, a, d, unused_rd);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus(1'b1, 1'b1, a, 8'h00, d);
  endtask

  task automatic seq_to(input int v);
    while (pos < v) step();
  endtask

  task automatic wait_halfs(input string tag, input int n);
    int budget = 0;
    while (halfs < n && budget < 5000) begin
      step();
      budget++;
    end
    chk(tag, 32'(halfs), 32'(n));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_irq_n", 32'(irq_n), 32'd1);
    chk("rst_qtr", 32'(qtr_frame), 32'd0);
    chk("rst_half", 32'(half_frame), 32'd0);
    chk("rst_ch_ena", 32'(ch_ena), 32'h0);
    chk("rst_len_active", 32'(len_active), 32'h0);
    chk("rst_rdata_idle", 32'(reg_rdata), 32'h00);

    // DMC IRQ pass-through and read decode
    dmc_irq = 1'b1; #1;
    chk("dmc_irq_n", 32'(irq_n), 32'd0);
    rd(16'h4015, rdv);
    chk("dmc_rdata", 32'(rdv), 32'h80);
    rd(16'h4014, rdv);
    chk("other_addr_rdata", 32'(rdv), 32'h00);
    dmc_irq = 1'b0; #1;
    chk("dmc_irq_n_clear", 32'(irq_n), 32'd1);

    // Mode 0 sequence
    wr(16'h4015, 8'h0F);
    chk("ch_ena_all", 32'(ch_ena), 32'hF);
    wr(16'h4017, 8'h00);
    chk("m0_wr_no_pulse", 32'(qtr_frame), 32'd0);
    seq_to(S1);
    chk("m0_pre_s1", 32'(qtr_frame), 32'd0);
    step();
    chk("m0_s1_qtr", 32'(qtr_frame), 32'd1);
    chk("m0_s1_half", 32'(half_frame), 32'd0);
    step();
    chk("m0_s1_one_cycle", 32'(qtr_frame), 32'd0);
    seq_to(S2); step();
    chk("m0_s2_qh", 32'({qtr_frame, half_frame}), 32'b11);
    seq_to(S3); step();
    chk("m0_s3_qh", 32'({qtr_frame, half_frame}), 32'b10);
    seq_to(S4);
    chk("m0_pre_s4_irq_n", 32'(irq_n), 32'd1);
    step(); pos = 0;
    chk("m0_s4_qh", 32'({qtr_frame, half_frame}), 32'b11);
    chk("m0_s4_irq_n", 32'(irq_n), 32'd0);
    step();
    chk("m0_after_s4_qh", 32'({qtr_frame, half_frame}), 32'b00);
    rd(16'h4015, rdv);
    chk("irq_read_set", 32'(rdv), 32'h40);
    chk("irq_read_cleared", 32'(irq_n), 32'd1);
    rd(16'h4015, rdv);
    chk("irq_second_read", 32'(rdv), 32'h00);
    seq_to(S1); step();
    chk("m0_wrap_s1_qtr", 32'(qtr_frame), 32'd1);

    // Read coinciding with STEP4: set beats clear
    seq_to(S4);
    rd(16'h4015, rdv); pos = 0;
    chk("coincide_rdata", 32'(rdv), 32'h00);
    chk("coincide_irq_n", 32'(irq_n), 32'd0);
    chk("coincide_qh", 32'({qtr_frame, half_frame}), 32'b11);
    wr(16'h4017, 8'h40);
    chk("inhibit_clears_irq", 32'(irq_n), 32'd1);
    chk("wr0x40_no_pulse", 32'(qtr_frame), 32'd0);

    // Inhibited mode 0: no IRQ at STEP4
    seq_to(S4); step(); pos = 0;
    chk("inh_s4_half", 32'(half_frame), 32'd1);
    chk("inh_s4_irq_n", 32'(irq_n), 32'd1);

    // 5-step mode
    wr(16'h4017, 8'h80);
    chk("m1_immediate_qh", 32'({qtr_frame, half_frame}), 32'b11);
    step();
    chk("m1_immediate_once", 32'({qtr_frame, half_frame}), 32'b00);
    seq_to(S1); step();
    chk("m1_s1_qtr", 32'(qtr_frame), 32'd1);
    seq_to(S4); step();
    chk("m1_s4_no_event", 32'({qtr_frame, half_frame}), 32'b00);
    chk("m1_s4_irq_n", 32'(irq_n), 32'd1);
    seq_to(S5); step(); pos = 0;
    chk("m1_s5_qh", 32'({qtr_frame, half_frame}), 32'b11);
    chk("m1_s5_irq_n", 32'(irq_n), 32'd1);
    seq_to(S1); step();
    chk("m1_wrap_s1_qtr", 32'(qtr_frame), 32'd1);

    // Length counter: load 254 and count down
    wr(16'h4017, 8'h40);
    wr(16'h4000, 8'h00);
    wr(16'h4003, 8'h08);
    chk("len_load_active", 32'(len_active), 32'h1);
    rd(16'h4015, rdv);
    chk("len_status_read", 32'(rdv), 32'h01);
    halfs = 0;
    wait_halfs("len_253_halfs", 253); step();
    chk("len_after_253", 32'(len_active), 32'h1);
    wait_halfs("len_254_halfs", 254); step();
    chk("len_after_254", 32'(len_active), 32'h0);

    // Halt: ch0 via bit5, triangle ignores bit5
    wr(16'h4017, 8'h40);
    wr(16'h4000, 8'h20);
    wr(16'h4008, 8'h20);
    wr(16'h4003, 8'h18);
    wr(16'h400B, 8'h18);
    chk("halt_load_two", 32'(len_active), 32'h5);
    halfs = 0;
    wait_halfs("halt_1_half", 1); step();
    chk("halt_after_1", 32'(len_active), 32'h5);
    wait_halfs("halt_2_halfs", 2); step();
    chk("halt_after_2", 32'(len_active), 32'h1);

    // Release ch0, halt triangle via bit7
    wr(16'h4017, 8'h40);
    wr(16'h4000, 8'h00);
    wr(16'h4008, 8'h80);
    wr(16'h400B, 8'h18);
    chk("tri_halt_load", 32'(len_active), 32'h5);
    halfs = 0;
    wait_halfs("tri_2_halfs", 2); step();
    chk("tri_halt_hold", 32'(len_active), 32'h4);

    // Disable clears, disabled channel ignores loads
    wr(16'h4015, 8'h0B);
    chk("disable_clears_tri", 32'(len_active), 32'h0);
    wr(16'h4003, 8'h08);
    chk("enabled_load", 32'(len_active), 32'h1);
    wr(16'h4015, 8'h0A);
    chk("disable_clears_ch0", 32'(len_active), 32'h0);
    chk("ch_ena_0a", 32'(ch_ena), 32'hA);
    wr(16'h4003, 8'h08);
    chk("disabled_load_ignored", 32'(len_active), 32'h0);

    // Mid-operation reset with IRQ pending
    wr(16'h4015, 8'h0F);
    wr(16'h4003, 8'h08);
    wr(16'h4017, 8'h00);
    seq_to(S4); step(); pos = 0;
    chk("pre_rst_irq_n", 32'(irq_n), 32'd0);
    chk("pre_rst_half", 32'(half_frame), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_irq_n", 32'(irq_n), 32'd1);
    chk("mid_rst_len", 32'(len_active), 32'h0);
    chk("mid_rst_ch_ena", 32'(ch_ena), 32'h0);
    chk("mid_rst_pulses", 32'({qtr_frame, half_frame}), 32'b00);
    @(posedge clk); #1 rst = 1'b0;
    pos = 0;
    seq_to(S1);
    chk("post_rst_pre_s1", 32'(qtr_frame), 32'd0);
    step();
    chk("post_rst_s1_qtr", 32'(qtr_frame), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
